// File: rtl/score_keeper_if.sv
// Signal bundle between the ball mover / score renderer side (master) and score_keeper (slave).
interface score_keeper_if;
    logic [11:0] ball_center_col;
    logic        start;
    logic [3:0]  l_score;
    logic [3:0]  r_score;
    logic        ball_hold;
    logic        serve;
    logic        game_over;
    logic        winner;

    modport master (
        output ball_center_col, start,
        input  l_score, r_score, ball_hold, serve, game_over, winner
    );

    modport slave (
        input  ball_center_col, start,
        output l_score, r_score, ball_hold, serve, game_over, winner
    );
endinterface

// File: rtl/score_keeper.sv
// Pong game-flow and scoring controller: miss detection, serve delay, idle/play/over sequencing.
// Define SCORE_KEEPER_WIN_EN to end the game at WIN_SCORE; otherwise scores wrap 9->0 forever.
module score_keeper #(
    parameter int unsigned DISP_COLS   = 800,
    parameter int unsigned B_WIDTH     = 6,
    parameter int unsigned L_GOAL_COL  = 2,
    parameter int unsigned R_GOAL_COL  = DISP_COLS - 3,
    parameter int unsigned WIN_SCORE   = 7,
    parameter logic [23:0] SERVE_DELAY = 24'd5_000_000
) (
    input logic              clk,
    input logic              rst_n,
    score_keeper_if.slave    sk
);

`ifdef SCORE_KEEPER_WIN_EN
    localparam bit WinEn = 1'b1;
`else
    localparam bit WinEn = 1'b0;
`endif

    localparam logic [12:0] LeftLim  = 13'(L_GOAL_COL + B_WIDTH / 2);
    localparam logic [12:0] HalfW    = 13'(B_WIDTH / 2);
    localparam logic [12:0] RightLim = 13'(R_GOAL_COL);
    localparam logic [3:0]  WinVal   = 4'(WIN_SCORE);

    typedef enum logic [1:0] {StIdle, StPlay, StScored, StOver} state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  l_q, l_d, r_q, r_d;
    logic        hold_q, hold_d;
    logic        serve_q, serve_d;
    logic        over_q, over_d;
    logic        winner_q, winner_d;
    logic        start_q;

    logic [12:0] col13;
    logic        press, left_miss, right_miss, win_hit;

    function automatic logic [3:0] inc_wrap(input logic [3:0] s);
        return (s == 4'd9) ? 4'd0 : s + 4'd1;
    endfunction

    // Widened compare, additions only: no wrap near column 0.
    assign col13      = {1'b0, sk.ball_center_col};
    assign left_miss  = col13 <= LeftLim;
    assign right_miss = (col13 + HalfW) >= RightLim;
    assign press      = sk.start & ~start_q;
    assign win_hit    = WinEn && ((l_q == WinVal) || (r_q == WinVal));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        l_d      = l_q;
        r_d      = r_q;
        hold_d   = hold_q;
        serve_d  = 1'b0;
        over_d   = over_q;
        winner_d = winner_q;
        unique case (state_q)
            StIdle: begin
                if (press) begin
                    l_d     = 4'd0;
                    r_d     = 4'd0;
                    cnt_d   = 24'd0;
                    hold_d  = 1'b1;
                    state_d = StScored;
                end
            end
            StPlay: begin
                // Skip the serve cycle so the mover can recentre before the next check.
                if (!serve_q) begin
                    if (left_miss) begin
                        r_d     = inc_wrap(r_q);
                        cnt_d   = 24'd0;
                        hold_d  = 1'b1;
                        state_d = StScored;
                    end else if (right_miss) begin
                        l_d     = inc_wrap(l_q);
                        cnt_d   = 24'd0;
                        hold_d  = 1'b1;
                        state_d = StScored;
                    end
                end
            end
            StScored: begin
                if (cnt_q == SERVE_DELAY - 24'd1) begin
                    cnt_d = 24'd0;
                    if (win_hit) begin
                        over_d   = 1'b1;
                        winner_d = (r_q == WinVal);
                        state_d  = StOver;
                    end else begin
                        serve_d = 1'b1;
                        hold_d  = 1'b0;
                        state_d = StPlay;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StOver: begin
                if (press) begin
                    over_d   = 1'b0;
                    winner_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 24'd0;
            l_q      <= 4'd0;
            r_q      <= 4'd0;
            hold_q   <= 1'b1;
            serve_q  <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            l_q      <= l_d;
            r_q      <= r_d;
            hold_q   <= hold_d;
            serve_q  <= serve_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            start_q  <= sk.start;
        end
    end

    assign sk.l_score   = l_q;
    assign sk.r_score   = r_q;
    assign sk.ball_hold = hold_q;
    assign sk.serve     = serve_q;
    assign sk.game_over = over_q;
    assign sk.winner    = winner_q;

endmodule
